// File: rtl/jts16_obj_draw_zoom.sv
// Sprite line drawer: fetches 4-bpp pixel words, applies horizontal shrink/enlarge, writes opaque pixels to the line buffer.
// Latency: first buffer write one cycle after the accepted SDRAM word; up to 2*PPW draw cycles per word.
module jts16_obj_draw_zoom #(
    parameter int DW       = 16,
    parameter int PALW     = 6,
    parameter int AW       = 20,
    parameter int MAXW     = 64,
    parameter int PRIO_MSB = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hstart,
    input  logic              start,
    output logic              busy,
    input  logic [8:0]        xpos,
    input  logic [AW-1:0]     addr,
    input  logic              hflip,
    input  logic [1:0]        prio,
    input  logic [PALW-1:0]   pal,
    input  logic [5:0]        hzoom,
    output logic              obj_cs,
    output logic [AW-1:0]     obj_addr,
    input  logic              obj_ok,
    input  logic [DW-1:0]     obj_data,
    output logic              bf_we,
    output logic [8:0]        bf_addr,
    output logic [5+PALW:0]   bf_data
);
    localparam int PPW = DW / 4;
    localparam int PIW = $clog2(PPW);
    localparam int WCW = $clog2(MAXW + 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAW, REPEAT} state_t;

    state_t            state_q, state_d;
    logic              busy_q, busy_d, obj_cs_q, obj_cs_d, bf_we_q, bf_we_d;
    logic [AW-1:0]     obj_addr_q, obj_addr_d;
    logic [8:0]        bf_addr_q, bf_addr_d, col_q, col_d;
    logic [5+PALW:0]   bf_data_q, bf_data_d;
    logic [5:0]        acc_q, acc_d, hzoom_q, hzoom_d;
    logic [WCW-1:0]    wc_q, wc_d;
    logic [PIW-1:0]    pidx_q, pidx_d;
    logic [DW-1:0]     shr_q, shr_d;
    logic              hflip_q, hflip_d, stale_q, stale_d, rep_last_q, rep_last_d;
    logic [1:0]        prio_q, prio_d;
    logic [PALW-1:0]   pal_q, pal_d;
    logic [3:0]        rep_pxl_q, rep_pxl_d;

    logic [3:0]        pxl, end_pxl;
    logic [6:0]        sum;
    logic              word_done;

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        obj_cs_d   = obj_cs_q;
        obj_addr_d = obj_addr_q;
        bf_we_d    = 1'b0;
        bf_addr_d  = bf_addr_q;
        bf_data_d  = bf_data_q;
        col_d      = col_q;
        acc_d      = acc_q;
        hzoom_d    = hzoom_q;
        wc_d       = wc_q;
        pidx_d     = pidx_q;
        shr_d      = shr_q;
        hflip_d    = hflip_q;
        stale_d    = stale_q;
        rep_last_d = rep_last_q;
        prio_d     = prio_q;
        pal_d      = pal_q;
        rep_pxl_d  = rep_pxl_q;
        word_done  = 1'b0;
        end_pxl    = 4'h0;
        pxl        = hflip_q ? shr_q[3:0] : shr_q[DW-1 -: 4];
        sum        = {1'b0, acc_q} + {2'b00, hzoom_q[4:0]};

        case (state_q)
            IDLE: if (start) begin
                obj_addr_d = addr;
                hflip_d    = hflip;
                prio_d     = prio;
                pal_d      = pal;
                hzoom_d    = hzoom;
                bf_addr_d  = xpos;
                col_d      = xpos;
                acc_d      = {hzoom[3:0], 2'b00};
                wc_d       = '0;
                busy_d     = 1'b1;
                obj_cs_d   = 1'b1;
                stale_d    = 1'b1;
                state_d    = FETCH;
            end
            FETCH: begin
                // obj_ok in the first request cycle belongs to the previous access
                if (stale_q) begin
                    stale_d = 1'b0;
                end else if (obj_ok) begin
                    shr_d    = obj_data;
                    obj_cs_d = 1'b0;
                    wc_d     = wc_q + 1'b1;
                    pidx_d   = '0;
                    state_d  = DRAW;
                end
            end
            DRAW: begin
                acc_d      = sum[5:0];
                shr_d      = hflip_q ? (shr_q >> 4) : (shr_q << 4);
                pidx_d     = pidx_q + 1'b1;
                rep_pxl_d  = pxl;
                rep_last_d = (pidx_q == PIW'(PPW - 1));
                if (hzoom_q[5] || !sum[6]) begin
                    bf_we_d   = (pxl != 4'hF);
                    bf_addr_d = col_q;
                    bf_data_d = (PRIO_MSB != 0) ? {prio_q, pal_q, pxl} : {pal_q, prio_q, pxl};
                    col_d     = col_q + 9'd1;
                end
                if (hzoom_q[5] && sum[6]) begin
                    state_d = REPEAT;
                end else if (pidx_q == PIW'(PPW - 1)) begin
                    word_done = 1'b1;
                    end_pxl   = pxl;
                end
            end
            REPEAT: begin
                bf_we_d   = (rep_pxl_q != 4'hF);
                bf_addr_d = col_q;
                bf_data_d = (PRIO_MSB != 0) ? {prio_q, pal_q, rep_pxl_q} : {pal_q, prio_q, rep_pxl_q};
                col_d     = col_q + 9'd1;
                state_d   = DRAW;
                if (rep_last_q) begin
                    word_done = 1'b1;
                    end_pxl   = rep_pxl_q;
                end
            end
            default: state_d = IDLE;
        endcase

        // A transparent last pixel marks the sprite end; MAXW guards against missing terminators
        if (word_done) begin
            if (end_pxl == 4'hF || wc_q == WCW'(MAXW)) begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end else begin
                obj_addr_d = hflip_q ? obj_addr_q - AW'(1) : obj_addr_q + AW'(1);
                obj_cs_d   = 1'b1;
                stale_d    = 1'b1;
                state_d    = FETCH;
            end
        end

        if (hstart) begin
            state_d  = IDLE;
            busy_d   = 1'b0;
            obj_cs_d = 1'b0;
            bf_we_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            obj_cs_q   <= 1'b0;
            obj_addr_q <= '0;
            bf_we_q    <= 1'b0;
            bf_addr_q  <= '0;
            bf_data_q  <= '0;
            col_q      <= '0;
            acc_q      <= '0;
            hzoom_q    <= '0;
            wc_q       <= '0;
            pidx_q     <= '0;
            shr_q      <= '0;
            hflip_q    <= 1'b0;
            stale_q    <= 1'b0;
            rep_last_q <= 1'b0;
            prio_q     <= '0;
            pal_q      <= '0;
            rep_pxl_q  <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            obj_cs_q   <= obj_cs_d;
            obj_addr_q <= obj_addr_d;
            bf_we_q    <= bf_we_d;
            bf_addr_q  <= bf_addr_d;
            bf_data_q  <= bf_data_d;
            col_q      <= col_d;
            acc_q      <= acc_d;
            hzoom_q    <= hzoom_d;
            wc_q       <= wc_d;
            pidx_q     <= pidx_d;
            shr_q      <= shr_d;
            hflip_q    <= hflip_d;
            stale_q    <= stale_d;
            rep_last_q <= rep_last_d;
            prio_q     <= prio_d;
            pal_q      <= pal_d;
            rep_pxl_q  <= rep_pxl_d;
        end
    end

    assign busy     = busy_q;
    assign obj_cs   = obj_cs_q;
    assign obj_addr = obj_addr_q;
    assign bf_we    = bf_we_q;
    assign bf_addr  = bf_addr_q;
    assign bf_data  = bf_data_q;
endmodule

// File: tb/tb_jts16_obj_draw_zoom.sv
// Bench for jts16_obj_draw_zoom: a 16-bit/MAXW=4 instance and a 32-bit Out Run style instance
// share stimulus; every job is checked write-by-write against a plain-arithmetic line model.
module tb_jts16_obj_draw_zoom;
    logic        clk = 1'b0;
    logic        rst, hstart, start, sel;
    logic [8:0]  xpos;
    logic [19:0] addr;
    logic        hflip;
    logic [1:0]  prio;
    logic [6:0]  pal;
    logic [5:0]  hzoom;

    logic        busy16, cs16, ok16, we16;
    logic [19:0] oa16;
    logic [15:0] od16;
    logic [8:0]  ba16;
    logic [11:0] bd16;
    logic        busy32, cs32, ok32, we32;
    logic [19:0] oa32;
    logic [31:0] od32;
    logic [8:0]  ba32;
    logic [12:0] bd32;

    logic [31:0] mem [256];
    int unsigned cnt16, cnt32, lat16, lat32;
    int          n_chk = 0, n_fail = 0;
    int          wq16[$], wq32[$], fq16[$], fq32[$];
    int          ew[$], ef[$];
    logic        pcs16 = 1'b0, pcs32 = 1'b0;

    always #5 clk = ~clk;

    jts16_obj_draw_zoom #(.DW(16), .PALW(6), .AW(20), .MAXW(4), .PRIO_MSB(0)) u16 (
        .clk(clk), .rst(rst), .hstart(hstart), .start(start & ~sel), .busy(busy16),
        .xpos(xpos), .addr(addr), .hflip(hflip), .prio(prio), .pal(pal[5:0]), .hzoom(hzoom),
        .obj_cs(cs16), .obj_addr(oa16), .obj_ok(ok16), .obj_data(od16),
        .bf_we(we16), .bf_addr(ba16), .bf_data(bd16));

    jts16_obj_draw_zoom #(.DW(32), .PALW(7), .AW(20), .MAXW(64), .PRIO_MSB(1)) u32 (
        .clk(clk), .rst(rst), .hstart(hstart), .start(start & sel), .busy(busy32),
        .xpos(xpos), .addr(addr), .hflip(hflip), .prio(prio), .pal(pal), .hzoom(hzoom),
        .obj_cs(cs32), .obj_addr(oa32), .obj_ok(ok32), .obj_data(od32),
        .bf_we(we32), .bf_addr(ba32), .bf_data(bd32));

    // SDRAM model: the first request cycle carries all-F garbage, which must never be accepted
    assign ok16 = cs16 && (cnt16 >= lat16);
    assign od16 = (cnt16 == 0) ? 16'hFFFF : mem[oa16[7:0]][15:0];
    assign ok32 = cs32 && (cnt32 >= lat32);
    assign od32 = (cnt32 == 0) ? 32'hFFFF_FFFF : mem[oa32[7:0]];

    always @(posedge clk) begin
        cnt16 <= cs16 ? cnt16 + 1 : 0;
        cnt32 <= cs32 ? cnt32 + 1 : 0;
    end

    always @(negedge clk) begin
        if (we16) wq16.push_back(int'(ba16) * 65536 + int'(bd16));
        if (we32) wq32.push_back(int'(ba32) * 65536 + int'(bd32));
        if (cs16 && !pcs16) fq16.push_back(int'(oa16));
        if (cs32 && !pcs32) fq32.push_back(int'(oa32));
        pcs16 = cs16;
        pcs32 = cs32;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: walk words and source pixels, producing the expected writes and fetch addresses
    task automatic model(input logic s, input int x, input int a, input logic hf,
                         input int pr, input int pl, input int hz);
        int ppw = s ? 8 : 4;
        int maxw = s ? 64 : 4;
        int col = x, acc = (hz % 16) * 4, step = hz % 32, nw = 0, wa = a;
        int nib, last, reps, dat;
        logic [31:0] w;
        ew.delete();
        ef.delete();
        forever begin
            ef.push_back(wa);
            w = mem[wa % 256];
            nw++;
            last = 0;
            for (int i = 0; i < ppw; i++) begin
                nib = hf ? int'((w >> (4 * i)) & 32'hF) : int'((w >> (4 * (ppw - 1 - i))) & 32'hF);
                acc = acc + step;
                reps = (hz >= 32) ? ((acc >= 64) ? 2 : 1) : ((acc >= 64) ? 0 : 1);
                acc = acc % 64;
                dat = s ? (pr * 2048 + (pl % 128) * 16 + nib) : ((pl % 64) * 64 + pr * 16 + nib);
                for (int r = 0; r < reps; r++) begin
                    if (nib != 15) ew.push_back(col * 65536 + dat);
                    col = (col + 1) % 512;
                end
                last = nib;
            end
            if (last == 15 || nw == maxw) break;
            wa = hf ? (wa + 1048575) % 1048576 : (wa + 1) % 1048576;
        end
    endtask

    task automatic pulse_hstart();
        hstart = 1'b1;
        @(posedge clk); #1;
        hstart = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if (!(sel ? busy32 : busy16)) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic run_job(input string tag, input logic s, input int x, input int a, input logic hf,
                           input int pr, input int pl, input int hz);
        int gw[$], gf[$];
        bit ok;
        pulse_hstart();
        sel = s;
        lat16 = $urandom_range(0, 3);
        lat32 = $urandom_range(0, 3);
        model(s, x, a, hf, pr, pl, hz);
        wq16.delete(); wq32.delete(); fq16.delete(); fq32.delete();
        xpos = 9'(x); addr = 20'(a); hflip = hf; prio = 2'(pr); pal = 7'(pl); hzoom = 6'(hz);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy_up"}, s ? busy32 : busy16, 1);
        wait_idle(ok);
        check({tag, "_done"}, ok, 1);
        repeat (3) @(posedge clk);
        #1;
        gw = s ? wq32 : wq16;
        gf = s ? fq32 : fq16;
        check({tag, "_nwrites"}, gw.size(), ew.size());
        for (int i = 0; i < gw.size() && i < ew.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), gw[i], ew[i]);
        check({tag, "_nfetch"}, gf.size(), ef.size());
        for (int i = 0; i < gf.size() && i < ef.size(); i++)
            check($sformatf("%s_fetch%0d", tag, i), gf[i], ef[i]);
    endtask

    task automatic fill_mem(input int fprob);
        for (int i = 0; i < 256; i++)
            for (int k = 0; k < 8; k++)
                mem[i][4*k +: 4] = ($urandom_range(0, 99) < fprob) ? 4'hF : 4'($urandom_range(0, 14));
    endtask

    initial begin
        bit ok;
        rst = 1'b1; hstart = 1'b0; start = 1'b0; sel = 1'b0;
        xpos = '0; addr = '0; hflip = 1'b0; prio = '0; pal = '0; hzoom = '0;
        lat16 = 0; lat32 = 0;
        fill_mem(0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {busy16, busy32}, 0);
        check("rst_cs", {cs16, cs32}, 0);
        check("rst_we", {we16, we32}, 0);
        check("rst_bfaddr", {ba16, ba32}, 0);
        check("rst_objaddr", {oa16, oa32}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        mem[100] = 32'h0000_123F;
        run_job("basic16", 1'b0, 10, 100, 1'b0, 2, 33, 6'h00);
        check("basic16_count", wq16.size(), 3);

        mem[50] = 32'h0000_0001;
        mem[49] = 32'hF000_0000;
        run_job("flip32", 1'b1, 20, 50, 1'b1, 1, 90, 6'h00);
        check("flip32_fetches", fq32.size(), 2);

        fill_mem(0);
        run_job("shrink", 1'b0, 40, 7, 1'b0, 3, 5, 6'h1F);
        run_job("enlarge", 1'b0, 508, 200, 1'b0, 1, 17, 6'h3F);
        run_job("maxw", 1'b0, 100, 0, 1'b1, 0, 63, 6'h2A);
        check("maxw_fetches", fq16.size(), 4);

        for (int j = 0; j < 24; j++) begin
            fill_mem(12);
            run_job($sformatf("rnd%0d", j), 1'($urandom_range(0, 1)), $urandom_range(0, 511),
                    $urandom_range(0, 255), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                    $urandom_range(0, 127), $urandom_range(0, 63));
        end

        // Abort in the middle of drawing
        fill_mem(0);
        sel = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            if (we16) ok = 1'b1; else begin @(posedge clk); #1; end
        end
        check("abort_saw_draw", ok, 1);
        pulse_hstart();
        check("abort_busy", busy16, 0);
        check("abort_cs", cs16, 0);
        check("abort_we", we16, 0);

        // hstart beats a simultaneous start
        start = 1'b1; hstart = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; hstart = 1'b0;
        check("hstart_wins", busy16, 0);

        // Asynchronous reset while a fetch is pending
        lat16 = 8;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("rstmid_in_fetch", cs16, 1);
        #2 rst = 1'b1;
        #1;
        check("rstmid_busy", busy16, 0);
        check("rstmid_cs", cs16, 0);
        check("rstmid_we", we16, 0);
        check("rstmid_addrs", {ba16, oa16}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
